// File: rtl/spu_issue_pkg.sv
// rtl/spu_issue_pkg.sv - pipe/state types and opcode classification for spu_dual_issue
package spu_issue_pkg;

    typedef enum logic {EVEN = 1'b0, ODD = 1'b1} pipe_t;
    typedef enum logic {PAIR = 1'b0, SPLIT = 1'b1} issue_state_t;

    // Register fields of an instruction: ra, rb, rc plus a mask of which are read
    typedef struct packed {
        logic [6:0] ra;
        logic [6:0] rb;
        logic [6:0] rc;
        logic [2:0] used;
    } src_regs_t;

    // Encoding families recognised by the classifier
    typedef enum logic [1:0] {FMT_RRR, FMT_LOAD, FMT_STORE, FMT_RR} fmt_t;

    typedef struct packed {
        pipe_t pipe;
        logic  wr;
        fmt_t  fmt;
    } op_class_t;

    localparam logic [3:0] OP4_SHUFB = 4'hB;
    localparam logic [3:0] OP4_FMA   = 4'hE;
    localparam logic [7:0] OP8_LQD   = 8'h34;
    localparam logic [7:0] OP8_STQD  = 8'h24;

    // Opcode classification table; the 4-bit RRR opcodes are matched first,
    // then 8-bit RI10 loads/stores; anything else is treated as an even RR op
    function automatic op_class_t classify(input logic [31:0] instr);
        op_class_t c;
        if (instr[31:28] == OP4_SHUFB)     c = '{pipe: ODD,  wr: 1'b1, fmt: FMT_RRR};
        else if (instr[31:28] == OP4_FMA)  c = '{pipe: EVEN, wr: 1'b1, fmt: FMT_RRR};
        else if (instr[31:24] == OP8_LQD)  c = '{pipe: ODD,  wr: 1'b1, fmt: FMT_LOAD};
        else if (instr[31:24] == OP8_STQD) c = '{pipe: ODD,  wr: 1'b0, fmt: FMT_STORE};
        else                               c = '{pipe: EVEN, wr: 1'b1, fmt: FMT_RR};
        return c;
    endfunction

    function automatic pipe_t pipe_of(input logic [31:0] instr);
        op_class_t c;
        c = classify(instr);
        return c.pipe;
    endfunction

    function automatic logic writes_rt(input logic [31:0] instr);
        op_class_t c;
        c = classify(instr);
        return c.wr;
    endfunction

    // RRR places RT in the upper field; every other format keeps it in the low 7 bits
    function automatic logic [6:0] dst_reg(input logic [31:0] instr);
        op_class_t c;
        c = classify(instr);
        return (c.fmt == FMT_RRR) ? instr[27:21] : instr[6:0];
    endfunction

    // A store reads its RT field as data, reported in the rc slot
    function automatic src_regs_t src_regs(input logic [31:0] instr);
        op_class_t c;
        src_regs_t s;
        c = classify(instr);
        s.ra = instr[13:7];
        s.rb = instr[20:14];
        s.rc = instr[6:0];
        case (c.fmt)
            FMT_RRR:   s.used = 3'b111;
            FMT_LOAD:  s.used = 3'b001;
            FMT_STORE: s.used = 3'b101;
            default:   s.used = 3'b011;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/spu_pair_check.sv
// rtl/spu_pair_check.sv - pair legality check; SPU_DUAL_ISSUE_EN enables dual issue
module spu_pair_check
    import spu_issue_pkg::*;
#(
    parameter int INSTR_W = 32
) (
    input  logic [INSTR_W-1:0] instr0,
    input  logic [INSTR_W-1:0] instr1,
    output logic               dual_ok,
    output logic               pipe0,
    output logic               pipe1
);

`ifdef SPU_DUAL_ISSUE_EN
    localparam logic DUAL_EN = 1'b1;
`else
    localparam logic DUAL_EN = 1'b0;
`endif

    src_regs_t  src1;
    logic [6:0] dst0;
    logic       raw;
    logic       waw;

    // Hazard detection between the older and younger instruction of the pair
    always_comb begin
        src1  = src_regs(instr1);
        dst0  = dst_reg(instr0);
        pipe0 = pipe_of(instr0);
        pipe1 = pipe_of(instr1);
        raw   = writes_rt(instr0) &&
                ((src1.used[0] && (src1.ra == dst0)) ||
                 (src1.used[1] && (src1.rb == dst0)) ||
                 (src1.used[2] && (src1.rc == dst0)));
        waw   = writes_rt(instr0) && writes_rt(instr1) && (dst_reg(instr1) == dst0);
        dual_ok = DUAL_EN && (pipe0 == EVEN) && (pipe1 == ODD) && !raw && !waw;
    end

endmodule

// File: rtl/spu_dual_issue.sv
// rtl/spu_dual_issue.sv - dual-issue router from fetch pair to ID1/ID2 (SPU_DUAL_ISSUE_EN)
module spu_dual_issue
    import spu_issue_pkg::*;
#(
    parameter int PC_W    = 32,
    parameter int INSTR_W = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [INSTR_W-1:0] instr0_IF,
    input  logic [INSTR_W-1:0] instr1_IF,
    input  logic [PC_W-1:0]    pc_IF,
    input  logic               valid_IF,
    output logic               ready_IF,
    input  logic               stall,
    input  logic               flush,
    output logic [INSTR_W-1:0] instr_ID1,
    output logic [INSTR_W-1:0] instr_ID2,
    output logic [PC_W-1:0]    pc_ID1,
    output logic [PC_W-1:0]    pc_ID2,
    output logic               valid_ID1,
    output logic               valid_ID2
);

    issue_state_t       state;
    issue_state_t       next_state;
    logic [INSTR_W-1:0] hold_instr;
    logic [PC_W-1:0]    hold_pc;
    pipe_t              hold_pipe;
    logic               dual_ok;
    logic               pipe0;
    logic               pipe1;
    logic               accept;

    spu_pair_check #(.INSTR_W(INSTR_W)) u_pair_check (
        .instr0  (instr0_IF),
        .instr1  (instr1_IF),
        .dual_ok (dual_ok),
        .pipe0   (pipe0),
        .pipe1   (pipe1)
    );

    assign ready_IF = (state == PAIR) && !stall && !flush && !reset;
    assign accept   = valid_IF && ready_IF;

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= PAIR;
        else       state <= next_state;
    end

    // Next state: a split pair spends one extra cycle in SPLIT
    always_comb begin
        next_state = state;
        if (flush) begin
            next_state = PAIR;
        end else if (!stall) begin
            case (state)
                PAIR:    if (accept && !dual_ok) next_state = SPLIT;
                SPLIT:   next_state = PAIR;
                default: next_state = PAIR;
            endcase
        end
    end

    // Output slots and hold register; unused slots are driven to all-zero
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            valid_ID1  <= 1'b0;
            instr_ID1  <= '0;
            pc_ID1     <= '0;
            valid_ID2  <= 1'b0;
            instr_ID2  <= '0;
            pc_ID2     <= '0;
            hold_instr <= '0;
            hold_pc    <= '0;
            hold_pipe  <= EVEN;
        end else if (!stall) begin
            valid_ID1 <= 1'b0;
            instr_ID1 <= '0;
            pc_ID1    <= '0;
            valid_ID2 <= 1'b0;
            instr_ID2 <= '0;
            pc_ID2    <= '0;
            if (state == SPLIT) begin
                if (hold_pipe == ODD) begin
                    valid_ID2 <= 1'b1;
                    instr_ID2 <= hold_instr;
                    pc_ID2    <= hold_pc;
                end else begin
                    valid_ID1 <= 1'b1;
                    instr_ID1 <= hold_instr;
                    pc_ID1    <= hold_pc;
                end
            end else if (accept) begin
                if (dual_ok) begin
                    valid_ID1 <= 1'b1;
                    instr_ID1 <= instr0_IF;
                    pc_ID1    <= pc_IF;
                    valid_ID2 <= 1'b1;
                    instr_ID2 <= instr1_IF;
                    pc_ID2    <= pc_IF + PC_W'(4);
                end else begin
                    if (pipe_t'(pipe0) == ODD) begin
                        valid_ID2 <= 1'b1;
                        instr_ID2 <= instr0_IF;
                        pc_ID2    <= pc_IF;
                    end else begin
                        valid_ID1 <= 1'b1;
                        instr_ID1 <= instr0_IF;
                        pc_ID1    <= pc_IF;
                    end
                    hold_instr <= instr1_IF;
                    hold_pc    <= pc_IF + PC_W'(4);
                    hold_pipe  <= pipe_t'(pipe1);
                end
            end
        end
    end

endmodule
